dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: requester and memory address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter TIMEOUT, default 15: max BUSY cycles awaiting mem_ready; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  2  per-requester access request; bit0 = core, bit1 = debug.
REQ-007 we  input  2  per-requester write enable; 1 = store, 0 = load.
REQ-008 addr  input  2*ADDR_W  per-requester address; requester i in slice i.
REQ-009 wdata  input  2*DATA_W  per-requester store data; requester i in slice i.
REQ-010 gnt  output  2  one-hot accept strobe; request i accepted at the edge where req[i] and gnt[i] are both high.
REQ-011 rvalid  output  2  one-cycle response strobe to the owning requester.
REQ-012 rdata  output  DATA_W  load data, valid while any rvalid bit is high.
REQ-013 err  output  1  timeout flag, valid while any rvalid bit is high.
REQ-014 mem_en  output  1  memory access strobe, held for the whole access.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  ADDR_W  memory address.
REQ-017 mem_wdata  output  DATA_W  memory store data.
REQ-018 mem_rdata  input  DATA_W  memory load data, valid with mem_ready.
REQ-019 mem_ready  input  1  memory completion strobe.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-021 IDLE: gnt SHALL be combinational; with one req bit set, grant that requester; with both set, grant the requester not served last (round-robin); with none set, gnt = 0.
REQ-022 On acceptance: latch we/addr/wdata and the owner index; clear the wait counter; go to BUSY.
REQ-023 BUSY: mem_en = 1; mem_we/mem_addr/mem_wdata driven from the latch and stable for the whole state; gnt = 0.
REQ-024 BUSY with mem_ready = 1: capture mem_rdata (stores capture 0); set err = 0; go to RESP.
REQ-025 BUSY with mem_ready = 0: increment the wait counter; when it reaches TIMEOUT, go to RESP with err = 1 and rdata = 0.
REQ-026 RESP: rvalid[owner] = 1 for exactly one cycle with rdata/err; update the round-robin pointer to owner; return to IDLE.
REQ-027 Latency: accept at edge T0; mem_ready at edge Tk (k >= 1); rvalid high during cycle Tk+1.
REQ-028 Minimum turnaround is 3 cycles per transaction; no overlapping accesses.
REQ-029 mem_ready outside BUSY SHALL be ignored.
REQ-030 req changes outside IDLE SHALL have no effect.
REQ-031 gnt and rvalid SHALL each be one-hot or zero at all times.
REQ-032 Wait counter SHALL be 8 bits wide and never wrap; it is cleared on acceptance.

Reset
REQ-033 reset low SHALL asynchronously force: state IDLE; gnt, rvalid, err, mem_en and mem_we = 0; mem_addr, mem_wdata and rdata = 0; wait counter = 0.
REQ-034 Reset SHALL set the round-robin pointer to "debug served last", so core wins the first tie.
REQ-035 Reset asserted mid-transaction SHALL abandon the access with no rvalid, including after reset release.

Structure
REQ-036 Package dmem_arb_pkg SHALL hold the state enum (IDLE/BUSY/RESP), the REQ_CORE = 0 / REQ_DBG = 1 constants and the wait-counter width.
REQ-037 Round-robin selection SHALL live in sub-module rr_pick2 (inputs: req[1:0], last; output: one-hot grant), combinational.
REQ-038 All remaining logic (FSM, latches, counter) SHALL reside in dmem_arbiter.

Verification
REQ-039 Core load of addr 0x10; mem_ready on the first BUSY cycle with mem_rdata 0xDEADBEEF -> gnt[0] in IDLE; rvalid[0] two cycles after acceptance; rdata 0xDEADBEEF; err = 0.
REQ-040 Both requesters hold req continuously for 4 transactions after reset -> grant order core, debug, core, debug.
REQ-041 Debug store addr 0x20, wdata 0x1234; mem_ready after 3 BUSY cycles -> mem_we = 1 and mem_wdata 0x1234 stable for those 3 cycles; rvalid[1] the cycle after; rdata 0.
REQ-042 Core load with mem_ready never asserted, TIMEOUT = 15 -> mem_en high for 15 cycles; then rvalid[0] with err = 1 and rdata 0.
REQ-043 reset pulsed low during BUSY -> outputs zero immediately; no rvalid; next tie goes to core.
REQ-044 mem_ready pulsed while IDLE, and req toggled during BUSY -> no state change and no extra gnt or rvalid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, requester indices and wait-counter width for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam int REQ_CORE = 0;
  localparam int REQ_DBG = 1;
  localparam int CNT_W = 8;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; req[1:0] in, last (index served last) in, one-hot gnt[1:0] out
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = (req == 2'b11) ? ((last == 1'(REQ_DBG)) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/debug arbiter in front of a single data memory; ports: clk, reset (async low), req/we/addr/wdata per requester, gnt/rvalid/rdata/err back, mem_* to memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);
  state_e            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        pick;
  rr_pick2 u_pick (.req(req), .last(last_q), .gnt(pick));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // last_q resets to debug so the core wins the first tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner_q <= 1'b0;
      last_q  <= 1'(REQ_DBG);
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  // counter leaves BUSY on reaching TIMEOUT, so it can never wrap
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|pick) begin
        owner_d = pick[REQ_DBG];
        we_d    = we[pick[REQ_DBG]];
        addr_d  = pick[REQ_DBG] ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        wdata_d = pick[REQ_DBG] ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: if (mem_ready) begin
        rdata_d = we_q ? '0 : mem_rdata;
        err_d   = 1'b0;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_W'(TIMEOUT)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // gnt is also masked by reset so it reads zero while reset is held
  always_comb begin
    gnt       = (state_q == IDLE && reset) ? pick : 2'b00;
    rvalid    = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    mem_en    = state_q == BUSY;
    mem_we    = (state_q == BUSY) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
    err       = err_q;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, reset/idle corner sequences and randomized transactions against a reference model
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  logic clk = 0, reset = 0;
  logic [1:0] req = 0, we = 0;
  logic [2*AW-1:0] addr = 0;
  logic [2*DW-1:0] wdata = 0;
  logic [1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = 0;
  logic [AW-1:0] mem_addr;
  logic err, mem_en, mem_we;
  logic mem_ready = 0;
  int n_chk = 0, n_fail = 0;
  logic last_m;
  always #5 clk = ~clk;
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );
  typedef struct {
    logic [1:0] rq, w;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, md;
    int dly;
    logic [1:0] eg;
    logic [DW-1:0] er;
    logic ee;
  } vec_t;
  vec_t tab[8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic zeros(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask
  // Entered and left at posedge+1 with the arbiter idle; dly = BUSY cycle carrying mem_ready, 0 = never
  task automatic txn(input vec_t v, input bit tog);
    logic win;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ready;
    win = v.eg[1];
    ea = win ? v.a1 : v.a0;
    ed = win ? v.d1 : v.d0;
    req = v.rq; we = v.w; addr = {v.a1, v.a0}; wdata = {v.d1, v.d0};
    #1 chk("gnt_idle", gnt, v.eg);
    @(posedge clk); #1;
    for (int k = 1; k <= TO; k++) begin
      if (tog) begin
        req = 2'($urandom_range(0, 3)); we = 2'($urandom_range(0, 3));
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      end
      ready = (k == v.dly);
      mem_ready = ready;
      mem_rdata = v.md;
      #1;
      chk("busy_gnt", gnt, 0);
      chk("busy_rvalid", rvalid, 0);
      chk("mem_en", mem_en, 1);
      chk("mem_we", mem_we, v.w[win]);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      @(posedge clk); #1;
      mem_ready = 0;
      mem_rdata = $urandom;
      if (ready) break;
    end
    if (tog) begin
      req = 2'($urandom_range(0, 3));
      mem_ready = 1'($urandom_range(0, 1));
    end
    #1;
    chk("rvalid", rvalid, win ? 2'b10 : 2'b01);
    chk("rdata", rdata, v.er);
    chk("err", err, v.ee);
    chk("resp_mem_en", mem_en, 0);
    chk("resp_gnt", gnt, 0);
    @(posedge clk); #1;
    mem_ready = 0;
    if (tog) req = 0;
    last_m = win;
  endtask
  // Reference model: lone requester wins; on a tie the one not served last wins
  function automatic vec_t rand_vec();
    vec_t v;
    int w;
    v.rq = 2'($urandom_range(1, 3));
    v.w = 2'($urandom_range(0, 3));
    v.a0 = $urandom; v.a1 = $urandom; v.d0 = $urandom; v.d1 = $urandom; v.md = $urandom;
    v.dly = $urandom_range(0, 5);
    if (v.rq == 2'b01) w = 0;
    else if (v.rq == 2'b10) w = 1;
    else w = (last_m == 1'b1) ? 0 : 1;
    v.eg = (w == 1) ? 2'b10 : 2'b01;
    v.ee = (v.dly == 0);
    v.er = (v.dly == 0 || v.w[w]) ? '0 : v.md;
    return v;
  endfunction
  initial begin
    tab[0] = '{rq:2'b11, w:2'b00, a0:32'h100, a1:32'h104, d0:0, d1:0, md:32'h1111_1111, dly:1, eg:2'b01, er:32'h1111_1111, ee:0};
    tab[1] = '{rq:2'b11, w:2'b11, a0:32'h200, a1:32'h204, d0:32'hA0, d1:32'hA1, md:32'h2222_2222, dly:2, eg:2'b10, er:0, ee:0};
    tab[2] = '{rq:2'b11, w:2'b10, a0:32'h300, a1:32'h304, d0:32'hB0, d1:32'hB1, md:32'h3333_3333, dly:1, eg:2'b01, er:32'h3333_3333, ee:0};
    tab[3] = '{rq:2'b11, w:2'b00, a0:32'h400, a1:32'h404, d0:0, d1:0, md:32'h4444_4444, dly:4, eg:2'b10, er:32'h4444_4444, ee:0};
    tab[4] = '{rq:2'b01, w:2'b00, a0:32'h10, a1:32'h0, d0:0, d1:0, md:32'hDEAD_BEEF, dly:1, eg:2'b01, er:32'hDEAD_BEEF, ee:0};
    tab[5] = '{rq:2'b10, w:2'b10, a0:32'h0, a1:32'h20, d0:0, d1:32'h1234, md:32'hAAAA_5555, dly:3, eg:2'b10, er:0, ee:0};
    tab[6] = '{rq:2'b01, w:2'b00, a0:32'h30, a1:32'h0, d0:0, d1:0, md:32'h5A5A_5A5A, dly:0, eg:2'b01, er:0, ee:1};
    tab[7] = '{rq:2'b11, w:2'b01, a0:32'h700, a1:32'h704, d0:32'hC0, d1:32'hC1, md:32'h7777_7777, dly:15, eg:2'b10, er:32'h7777_7777, ee:0};
    req = 2'b11;
    #12 zeros("reset");
    req = 0;
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    last_m = 1'b1;
    for (int i = 0; i < 8; i++) txn(tab[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      req = 0;
      mem_ready = 1;
      #1;
      chk("idle_ready_gnt", gnt, 0);
      chk("idle_ready_mem_en", mem_en, 0);
      chk("idle_ready_rvalid", rvalid, 0);
      @(posedge clk); #1;
    end
    mem_ready = 0;
    #1 chk("idle_after_ready_mem_en", mem_en, 0);
    chk("idle_after_ready_rvalid", rvalid, 0);
    for (int i = 0; i < 30; i++) begin
      txn(rand_vec(), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1 chk("gap_rvalid", rvalid, 0);
        chk("gap_mem_en", mem_en, 0);
        @(posedge clk); #1;
        mem_ready = 0;
      end
    end
    req = 2'b11; we = 2'b01; addr = {32'h44, 32'h33}; wdata = {32'h66, 32'h55};
    #1 chk("mid_gnt", gnt, (last_m == 1'b1) ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    chk("mid_busy", mem_en, 1);
    reset = 0;
    #1 zeros("mid_reset");
    mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    chk("mid_reset_held_rvalid", rvalid, 0);
    req = 0;
    reset = 1;
    last_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("post_reset_rvalid", rvalid, 0);
      chk("post_reset_mem_en", mem_en, 0);
      @(posedge clk); #1;
    end
    txn('{rq:2'b11, w:2'b00, a0:32'h80, a1:32'h84, d0:0, d1:0, md:32'h0BAD_F00D, dly:2, eg:2'b01, er:32'h0BAD_F00D, ee:0}, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
